rom_burst_arbiter: RTL and testbench

Shares the single synchronous read port of the 64×32 waveform/text ROM between two requesters, e.g. the tick-driven sample player and a debug/console reader. Each requester asks for a burst of consecutive words. The block grants bursts round-robin, drives the ROM address and read-enable one word per cycle with wrap-around, and returns the data with per-requester valid and last strobes. It sits between the requesters and the ROM, and is the only block that drives `rom_en` and `rom_addr`.

---
 rtl/rom_burst_arbiter.sv | 145 ++++++++++++++
 tb/tb_rom_burst_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_burst_arbiter.sv
// Round-robin arbiter sharing the single synchronous read port of a ROM between
// two burst requesters; returns shared read data with per-requester valid/last.
module rom_burst_arbiter #(
  parameter int AW  = 6,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] len0,
  input  logic [AW-1:0] len1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          rlast0,
  output logic          rlast1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t         state_q;
  logic           last_grant_q;
  logic           winner_d;
  logic [AW-1:0]  remain_q;
  logic [AW-1:0]  rom_addr_q;
  logic           rom_en_q;
  logic           gnt0_q;
  logic           gnt1_q;
  logic           busy_q;
  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] lst_q;
  logic [DW-1:0]  rdata_q;
  logic           rvalid0_q;
  logic           rvalid1_q;
  logic           rlast0_q;
  logic           rlast1_q;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    winner_d = last_grant_q;
    if (req0 && req1) begin
      winner_d = ~last_grant_q;
    end else if (req0) begin
      winner_d = 1'b0;
    end else if (req1) begin
      winner_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      remain_q     <= '0;
      rom_addr_q   <= '0;
      rom_en_q     <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            state_q      <= ISSUE;
            last_grant_q <= winner_d;
            gnt0_q       <= ~winner_d;
            gnt1_q       <= winner_d;
            rom_en_q     <= 1'b1;
            rom_addr_q   <= winner_d ? addr1 : addr0;
            remain_q     <= winner_d ? len1 : len0;
            busy_q       <= 1'b1;
          end
        end
        ISSUE: begin
          if (remain_q == '0) begin
            state_q  <= DRAIN;
            rom_en_q <= 1'b0;
          end else begin
            rom_addr_q <= rom_addr_q + AW'(1);
            remain_q   <= remain_q - AW'(1);
          end
        end
        DRAIN: begin
          // The final word has just been presented; the burst is complete.
          if (rlast0_q || rlast1_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Each issued read travels LAT stages so its flags line up with rom_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      lst_q     <= '0;
      rdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rlast0_q  <= 1'b0;
      rlast1_q  <= 1'b0;
    end else begin
      vld_q[0] <= rom_en_q;
      lst_q[0] <= rom_en_q && (remain_q == '0);
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        lst_q[i] <= lst_q[i-1];
      end
      rvalid0_q <= vld_q[LAT-1] && !last_grant_q;
      rvalid1_q <= vld_q[LAT-1] && last_grant_q;
      rlast0_q  <= vld_q[LAT-1] && lst_q[LAT-1] && !last_grant_q;
      rlast1_q  <= vld_q[LAT-1] && lst_q[LAT-1] && last_grant_q;
      if (vld_q[LAT-1]) begin
        rdata_q <= rom_data;
      end
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rlast0   = rlast0_q;
  assign rlast1   = rlast1_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Scoreboard bench for rom_burst_arbiter: a LAT=1 instance under directed and random
// bursts, plus a LAT=3 instance running the single-word latency case.
module tb_rom_burst_arbiter;

  localparam int AW   = 6;
  localparam int DW   = 32;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  typedef struct {
    bit          who;
    logic [31:0] data;
    bit          last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [64];

  // Main instance (LAT=1)
  logic          rst_n;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1, len0, len1;
  logic          gnt0, gnt1, rvalid0, rvalid1, rlast0, rlast1, busy, rom_en;
  logic [DW-1:0] rdata, rom_data;
  logic [AW-1:0] rom_addr;

  rom_burst_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rlast0(rlast0), .rlast1(rlast1), .rdata(rdata), .busy(busy),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  logic [31:0] romPipe [LAT];
  always @(posedge clk) begin
    romPipe[0] <= rom_en ? mem[rom_addr] : 32'hDEADBEEF;
    for (int i = 1; i < LAT; i++) romPipe[i] <= romPipe[i-1];
  end
  assign rom_data = romPipe[LAT-1];

  // Latency instance (LAT=3)
  logic          rst3N;
  logic          req0b, req1b;
  logic [AW-1:0] addr0b, addr1b, len0b, len1b;
  logic          gnt0b, gnt1b, rvalid0b, rvalid1b, rlast0b, rlast1b, busyb, romEnb;
  logic [DW-1:0] rdatab, romDatab;
  logic [AW-1:0] romAddrb;

  rom_burst_arbiter #(.AW(AW), .DW(DW), .LAT(LAT3)) u_dut3 (
    .clk(clk), .rst_n(rst3N),
    .req0(req0b), .req1(req1b), .addr0(addr0b), .addr1(addr1b), .len0(len0b), .len1(len1b),
    .gnt0(gnt0b), .gnt1(gnt1b), .rvalid0(rvalid0b), .rvalid1(rvalid1b),
    .rlast0(rlast0b), .rlast1(rlast1b), .rdata(rdatab), .busy(busyb),
    .rom_en(romEnb), .rom_addr(romAddrb), .rom_data(romDatab)
  );

  logic [31:0] romPipe3 [LAT3];
  always @(posedge clk) begin
    romPipe3[0] <= romEnb ? mem[romAddrb] : 32'hDEADBEEF;
    for (int i = 1; i < LAT3; i++) romPipe3[i] <= romPipe3[i-1];
  end
  assign romDatab = romPipe3[LAT3-1];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Scoreboard queues filled by the driver from the reference model.
  exp_t        expQ[$];
  logic [5:0]  addrQ[$];
  exp_t        monE;
  logic [5:0]  monA;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid0 || rvalid1) begin
        checkOutput("rvalidExclusive", {63'd0, rvalid0 && rvalid1}, 64'd0);
        if (expQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpectedRvalid: got rvalid0=%0b rvalid1=%0b, expected none", rvalid0, rvalid1);
        end else begin
          monE = expQ.pop_front();
          checkOutput("rvalidWho", {63'd0, rvalid1}, {63'd0, monE.who});
          checkOutput("rdata", {32'd0, rdata}, {32'd0, monE.data});
          checkOutput("rlast", {63'd0, monE.who ? rlast1 : rlast0}, {63'd0, monE.last});
        end
      end else if (rlast0 || rlast1) begin
        checks++; errors++;
        $display("[TB] FAIL strayRlast: got rlast0=%0b rlast1=%0b, expected 0 without rvalid", rlast0, rlast1);
      end
      if (rom_en) begin
        if (addrQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpectedRomEn: got rom_addr=%0d, expected rom_en=0", rom_addr);
        end else begin
          monA = addrQ.pop_front();
          checkOutput("romAddr", {58'd0, rom_addr}, {58'd0, monA});
        end
      end
      if (gnt0 && gnt1) begin
        checks++; errors++;
        $display("[TB] FAIL gntExclusive: got gnt0=1 gnt1=1, expected at most one");
      end
    end
  end

  // Reference model state: pending requests and round-robin memory.
  bit          pend0, pend1;
  logic [5:0]  pa0, pl0, pa1, pl1;
  bit          modelLast = 1'b1;
  bit          havePrev = 1'b0;
  int          prevG, prevN;

  task automatic serveOne();
    bit w;
    bit seen;
    logic [5:0] a, l, ak;
    if (!pend0 && !pend1) return;
    w = (pend0 && pend1) ? ~modelLast : !pend0;
    modelLast = w;
    a = w ? pa1 : pa0;
    l = w ? pl1 : pl0;
    for (int k = 0; k <= int'(l); k++) begin
      ak = a + k[5:0];
      addrQ.push_back(ak);
      expQ.push_back('{who: w, data: mem[ak], last: (k == int'(l))});
    end
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      seen = gnt0 || gnt1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("[TB] FAIL gntTimeout: got no gnt, expected gnt%0d", w);
      req0 = 0; req1 = 0; pend0 = 0; pend1 = 0;
      expQ.delete(); addrQ.delete(); havePrev = 0;
      return;
    end
    checkOutput("gnt0", {63'd0, gnt0}, {63'd0, !w});
    checkOutput("gnt1", {63'd0, gnt1}, {63'd0, w});
    if (havePrev) checkOutput("gntSpacing", 64'(cyc - prevG), 64'(prevN + LAT + 2));
    prevG = cyc; prevN = int'(l) + 1; havePrev = 1;
    if (w) begin req1 = 0; pend1 = 0; end
    else   begin req0 = 0; pend0 = 0; end
    seen = 1'b0;
    for (int c = 0; c < 90 && !seen; c++) begin
      @(negedge clk);
      seen = w ? rlast1 : rlast0;
    end
    if (!seen) begin
      checks++; errors++;
      $display("[TB] FAIL rlastTimeout: got no rlast%0d, expected one after %0d words", w, int'(l) + 1);
      havePrev = 0;
      return;
    end
    checkOutput("rlastCycle", 64'(cyc - prevG), 64'(int'(l) + 1 + LAT));
    checkOutput("busyAtLast", {63'd0, busy}, 64'd1);
    @(negedge clk);
    checkOutput("busyLow", {63'd0, busy}, 64'd0);
  endtask

  task automatic applyStimulus(input bit r0, input logic [5:0] a0, input logic [5:0] l0,
                               input bit r1, input logic [5:0] a1, input logic [5:0] l1);
    if (r0 && !pend0) begin
      pend0 = 1; pa0 = a0; pl0 = l0; req0 = 1; addr0 = a0; len0 = l0;
    end
    if (r1 && !pend1) begin
      pend1 = 1; pa1 = a1; pl1 = l1; req1 = 1; addr1 = a1; len1 = l1;
    end
    serveOne();
  endtask

  bit done3 = 1'b0;

  initial begin
    bit r0, r1;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[5] = 32'h41424344;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; len0 = 0; len1 = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", {63'd0, busy}, 64'd0);
    checkOutput("resetRomEn", {63'd0, rom_en}, 64'd0);
    checkOutput("resetRdata", {32'd0, rdata}, 64'd0);
    checkOutput("resetRomAddr", {58'd0, rom_addr}, 64'd0);
    rst_n = 1;
    @(negedge clk);

    $display("[TB] single-word and wrap-around bursts");
    applyStimulus(1, 6'd5, 6'd0, 0, 6'd0, 6'd0);
    applyStimulus(0, 6'd0, 6'd0, 1, 6'd62, 6'd3);

    $display("[TB] round-robin with both requests held");
    for (int i = 0; i < 4; i++) applyStimulus(1, 6'($urandom), 6'd0, 1, 6'($urandom), 6'd0);
    while (pend0 || pend1) serveOne();

    $display("[TB] maximum burst");
    applyStimulus(1, 6'd0, 6'd63, 0, 6'd0, 6'd0);

    $display("[TB] reset in the middle of a burst");
    pa0 = 6'd10; pl0 = 6'd7;
    for (int k = 0; k < 8; k++) begin
      addrQ.push_back(pa0 + k[5:0]);
      expQ.push_back('{who: 1'b0, data: mem[pa0 + k[5:0]], last: (k == 7)});
    end
    req0 = 1; addr0 = pa0; len0 = pl0;
    @(negedge clk);
    checkOutput("midGnt0", {63'd0, gnt0}, 64'd1);
    req0 = 0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    checkOutput("midResetStrobes", {56'd0, gnt0, gnt1, rvalid0, rvalid1, rlast0, rlast1, busy, rom_en}, 64'd0);
    checkOutput("midResetRdata", {32'd0, rdata}, 64'd0);
    checkOutput("midResetRomAddr", {58'd0, rom_addr}, 64'd0);
    expQ.delete(); addrQ.delete();
    modelLast = 1; havePrev = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("noRlastAfterReset", {62'd0, rlast0, rvalid0}, 64'd0);
    end
    applyStimulus(1, 6'd20, 6'd1, 1, 6'd30, 6'd1);
    while (pend0 || pend1) serveOne();

    $display("[TB] randomized bursts");
    for (int i = 0; i < 30; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1 && !pend0 && !pend1) r0 = 1;
      applyStimulus(r0, 6'($urandom), ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 5)),
                    r1, 6'($urandom), ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 5)));
    end
    while (pend0 || pend1) serveOne();
    repeat (4) @(negedge clk);
    checkOutput("expQDrained", 64'(expQ.size()), 64'd0);
    checkOutput("addrQDrained", 64'(addrQ.size()), 64'd0);

    for (int i = 0; i < 200 && !done3; i++) @(negedge clk);
    if (!done3) begin
      checks++; errors++;
      $display("[TB] FAIL lat3Timeout: got unfinished latency test, expected completion");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // LAT=3 single-word read: gnt in cycle 1, data in cycle 5, idle from cycle 6.
  initial begin
    req0b = 0; req1b = 0; addr0b = 0; addr1b = 0; len0b = 0; len1b = 0;
    rst3N = 0;
    repeat (2) @(negedge clk);
    checkOutput("lat3ResetBusy", {63'd0, busyb}, 64'd0);
    rst3N = 1;
    repeat (2) @(negedge clk);
    req0b = 1; addr0b = 6'd5; len0b = 6'd0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checkOutput("lat3Gnt0", {63'd0, gnt0b}, {63'd0, k == 1});
      checkOutput("lat3RomEn", {63'd0, romEnb}, {63'd0, k == 1});
      checkOutput("lat3Rvalid0", {62'd0, rvalid0b, rlast0b}, (k == 5) ? 64'd3 : 64'd0);
      checkOutput("lat3Rvalid1", {63'd0, rvalid1b}, 64'd0);
      checkOutput("lat3Busy", {63'd0, busyb}, {63'd0, k <= 5});
      if (k == 1) begin
        checkOutput("lat3RomAddr", {58'd0, romAddrb}, 64'd5);
        req0b = 0;
      end
      if (k == 5) checkOutput("lat3Rdata", {32'd0, rdatab}, 64'h41424344);
    end
    done3 = 1;
  end

endmodule
